// File: rtl/nios2_scan_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG scan master.
package nios2_scan_pkg;

    localparam int unsigned DefaultDrWidth = 38;
    localparam int unsigned DefaultIrWidth = 2;

    // Virtual IR codes understood by the debug module
    localparam logic [1:0] IrOcimem    = 2'd0;
    localparam logic [1:0] IrTracemem  = 2'd1;
    localparam logic [1:0] IrBreak     = 2'd2;
    localparam logic [1:0] IrTracectrl = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StUir,
        StCdr,
        StSdr,
        StUdr,
        StRsp
    } scan_state_e;

endpackage

// File: rtl/nios2_scan_tck_gen.sv
// Divided scan clock generator. While enabled, produces tck with TCK_DIV low
// cycles followed by TCK_DIV high cycles; held low with the divider cleared
// when disabled, so every scan starts at the beginning of a low phase.
module nios2_scan_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic tck_fall,
    output logic tck_pre_rise
);

    localparam int unsigned CntW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CntW-1:0] cnt_q;
    logic            tck_q;
    logic            phase_last;

    assign phase_last = (cnt_q == CntW'(TCK_DIV - 1));

    // Half-period counter and registered tck
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else if (phase_last) begin
            cnt_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tck          = tck_q;
    // Last high cycle: tck falls at the end of it (period boundary)
    assign tck_fall     = en && tck_q && phase_last;
    // Last low cycle: tck rises at the end of it (sample point)
    assign tck_pre_rise = en && !tck_q && phase_last;

endmodule

// File: rtl/nios2_debug_scan_master.sv
// Host-side virtual-JTAG scan master for the Nios II debug module.
// Plays UIR -> CDR -> SDR x DR_WIDTH -> UDR on a divided tck per command and
// returns the captured shift-out word.
// Optional feature: define NIOS2_SCAN_IR_READBACK_EN to register ir_out during
// UIR and return it on rsp_ir; otherwise rsp_ir is tied to zero.
module nios2_debug_scan_master
    import nios2_scan_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DefaultDrWidth,
    parameter int unsigned IR_WIDTH = DefaultIrWidth,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int unsigned BitCntW = $clog2(DR_WIDTH);

    scan_state_e         state_q, state_d;
    logic [BitCntW-1:0]  bit_cnt_q;
    logic [DR_WIDTH-1:0] dr_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                accept;
    logic                tck_en;
    logic                tck_fall;
    logic                tck_pre_rise;

    assign accept = cmd_valid && (state_q == StIdle);
    assign tck_en = (state_q != StIdle) && (state_q != StRsp);

    nios2_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (tck_en),
        .tck          (tck),
        .tck_fall     (tck_fall),
        .tck_pre_rise (tck_pre_rise)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: scan states advance only on the tck falling boundary
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StUir;
            StUir:   if (tck_fall) state_d = StCdr;
            StCdr:   if (tck_fall) state_d = StSdr;
            StSdr:   if (tck_fall && (bit_cnt_q == BitCntW'(DR_WIDTH - 1))) state_d = StUdr;
            StUdr:   if (tck_fall) state_d = StRsp;
            StRsp:   if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, shift-in register and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dr_q      <= '0;
            ir_q      <= '0;
            bit_cnt_q <= '0;
        end else if (accept) begin
            dr_q      <= cmd_data;
            ir_q      <= cmd_ir;
            bit_cnt_q <= '0;
        end else if ((state_q == StSdr) && tck_fall) begin
            dr_q      <= {1'b0, dr_q[DR_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
        end
    end

    // Capture tdo just before each SDR rising edge; LSB-first so the first
    // bit ends up at position 0 after DR_WIDTH shifts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_data_q <= '0;
        end else if ((state_q == StSdr) && tck_pre_rise) begin
            rsp_data_q <= {tdo, rsp_data_q[DR_WIDTH-1:1]};
        end
    end

`ifdef NIOS2_SCAN_IR_READBACK_EN
    logic [IR_WIDTH-1:0] ir_rb_q;

    // Target IR status sampled on the last low-phase cycle of UIR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_rb_q <= '0;
        end else if ((state_q == StUir) && tck_pre_rise) begin
            ir_rb_q <= ir_out;
        end
    end

    assign rsp_ir = ir_rb_q;
`else
    logic unused_ir_out;
    assign unused_ir_out = ^ir_out;
    assign rsp_ir        = '0;
`endif

    // State-decoded outputs; all change only with state_q, i.e. at tck fall
    always_comb begin
        cmd_ready      = (state_q == StIdle);
        rsp_valid      = (state_q == StRsp);
        jtag_state_rti = (state_q == StIdle) || (state_q == StRsp);
        vs_uir         = (state_q == StUir);
        vs_cdr         = (state_q == StCdr);
        vs_sdr         = (state_q == StSdr);
        vs_udr         = (state_q == StUdr);
        tdi            = (state_q == StSdr) && dr_q[0];
    end

    assign ir_in    = ir_q;
    assign rsp_data = rsp_data_q;

endmodule
